gate_test_seq: RTL and testbench



---
 rtl/gate_test_seq_pkg.sv | 31 +++
 rtl/gate_test_seq_lfsr32.sv | 28 ++
 rtl/gate_test_seq.sv | 215 +++++++++++++++++++++
 tb/tb_gate_test_seq.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/gate_test_seq_pkg.sv
// Shared types and constants for the gate_test_seq sequencer/checker.
// Contents: FSM and phase enums, LFSR polynomial, directed-pattern count,
// counter widths, and the one-step Galois LFSR update used by lfsr32.
package gate_test_pkg;

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    CHECK,
    DONE
  } state_e;

  typedef enum logic {
    RANDOM,
    DIRECTED
  } phase_e;

  // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
  localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;

  localparam int unsigned N_DIRECTED = 4;
  localparam int unsigned RAND_CNT_W = 16;
  localparam int unsigned DIR_CNT_W  = 3;
  localparam int unsigned DIR_IDX_W  = 2;

  // One Galois step: shift right, fold taps in when the bit shifted out is 1
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/gate_test_seq_lfsr32.sv
// 32-bit Galois LFSR used as the random vector source.
// Ports:
//   clk   - clock
//   rst   - synchronous active-high reset, loads seed
//   load  - reload seed (wins over shift)
//   seed  - value loaded on rst/load
//   shift - advance one step
//   q     - current LFSR state
module lfsr32
  import gate_test_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        shift,
  output logic [31:0] q
);

  always_ff @(posedge clk) begin
    if (rst || load) begin
      q <= seed;
    end else if (shift) begin
      q <= lfsr_step(q);
    end
  end

endmodule

// File: rtl/gate_test_seq.sv
// Stimulus sequencer and result checker for single-output N-input gates.
// Runs N_RANDOM_TESTS LFSR vectors then four directed patterns, holding each
// vector SETTLE_CYCLES cycles before comparing y_dut against y_golden.
// Ports:
//   clk, rst               - clock, synchronous active-high reset
//   start                  - begin a run (honoured in IDLE or DONE)
//   y_dut, y_golden        - outputs of the model under test and reference
//   a                      - shared stimulus vector
//   busy, done             - run in progress / run complete
//   all_passed             - in DONE, every check passed
//   fail_valid, fail_a     - mismatch pulse and the vector that caused it
//   random_passed/_total   - random-phase counters
//   directed_passed/_total - directed-phase counters
module gate_test_seq
  import gate_test_pkg::*;
#(
  parameter int unsigned N_INS          = 2,
  parameter int unsigned N_RANDOM_TESTS = 100,
  parameter int unsigned SETTLE_CYCLES  = 1,
  parameter logic [31:0] LFSR_SEED      = 32'hACE1_1234
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  y_dut,
  input  logic                  y_golden,
  output logic [N_INS-1:0]      a,
  output logic                  busy,
  output logic                  done,
  output logic                  all_passed,
  output logic                  fail_valid,
  output logic [N_INS-1:0]      fail_a,
  output logic [RAND_CNT_W-1:0] random_passed,
  output logic [RAND_CNT_W-1:0] random_total,
  output logic [DIR_CNT_W-1:0]  directed_passed,
  output logic [DIR_CNT_W-1:0]  directed_total
);

  localparam int unsigned HALF     = N_INS / 2;
  localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES) + 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

  state_e                state_q, state_d;
  phase_e                phase_q, phase_d;
  logic [SETTLE_W-1:0]   settle_q, settle_d;
  logic [DIR_IDX_W-1:0]  dir_idx_q, dir_idx_d;

  logic [N_INS-1:0]      a_d, fail_a_d;
  logic                  busy_d, done_d, all_passed_d, fail_valid_d;
  logic [RAND_CNT_W-1:0] rand_pass_d, rand_tot_d;
  logic [DIR_CNT_W-1:0]  dir_pass_d, dir_tot_d;

  logic                  lfsr_load, lfsr_shift, pass;
  logic [31:0]           lfsr_q, lfsr_nxt;
  logic                  unused_lfsr_bits;

  // Directed pattern table: ones, zeros, upper-half ones, lower-half ones
  function automatic logic [N_INS-1:0] dir_vec(input logic [DIR_IDX_W-1:0] idx);
    logic [N_INS-1:0] v;
    case (idx)
      2'd0:    v = '1;
      2'd1:    v = '0;
      2'd2:    v = {{HALF{1'b1}}, {HALF{1'b0}}};
      default: v = {{HALF{1'b0}}, {HALF{1'b1}}};
    endcase
    return v;
  endfunction

  function automatic logic [RAND_CNT_W-1:0] sat_inc_r(input logic [RAND_CNT_W-1:0] v);
    return (v == '1) ? v : v + RAND_CNT_W'(1);
  endfunction

  function automatic logic [DIR_CNT_W-1:0] sat_inc_d(input logic [DIR_CNT_W-1:0] v);
    return (v == '1) ? v : v + DIR_CNT_W'(1);
  endfunction

  lfsr32 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (lfsr_load),
    .seed  (LFSR_SEED),
    .shift (lfsr_shift),
    .q     (lfsr_q)
  );

  // The next random vector is loaded into a on the same edge the LFSR shifts
  assign lfsr_nxt         = lfsr_step(lfsr_q);
  assign unused_lfsr_bits = ^lfsr_nxt;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      phase_q         <= RANDOM;
      settle_q        <= '0;
      dir_idx_q       <= '0;
      a               <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      all_passed      <= 1'b0;
      fail_valid      <= 1'b0;
      fail_a          <= '0;
      random_passed   <= '0;
      random_total    <= '0;
      directed_passed <= '0;
      directed_total  <= '0;
    end else begin
      state_q         <= state_d;
      phase_q         <= phase_d;
      settle_q        <= settle_d;
      dir_idx_q       <= dir_idx_d;
      a               <= a_d;
      busy            <= busy_d;
      done            <= done_d;
      all_passed      <= all_passed_d;
      fail_valid      <= fail_valid_d;
      fail_a          <= fail_a_d;
      random_passed   <= rand_pass_d;
      random_total    <= rand_tot_d;
      directed_passed <= dir_pass_d;
      directed_total  <= dir_tot_d;
    end
  end

  // Next-state, counter and output logic
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    settle_d     = settle_q;
    dir_idx_d    = dir_idx_q;
    a_d          = a;
    fail_a_d     = fail_a;
    fail_valid_d = 1'b0;
    rand_pass_d  = random_passed;
    rand_tot_d   = random_total;
    dir_pass_d   = directed_passed;
    dir_tot_d    = directed_total;
    lfsr_load    = 1'b0;
    lfsr_shift   = 1'b0;
    pass         = (y_dut == y_golden);

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = APPLY;
          settle_d    = SETTLE_LOAD;
          dir_idx_d   = '0;
          lfsr_load   = 1'b1;
          fail_a_d    = '0;
          rand_pass_d = '0;
          rand_tot_d  = '0;
          dir_pass_d  = '0;
          dir_tot_d   = '0;
          if (N_RANDOM_TESTS == 0) begin
            phase_d = DIRECTED;
            a_d     = dir_vec(DIR_IDX_W'(0));
          end else begin
            phase_d = RANDOM;
            a_d     = LFSR_SEED[N_INS-1:0];
          end
        end
      end

      APPLY: begin
        if (settle_q == '0) begin
          state_d = CHECK;
        end else begin
          settle_d = settle_q - SETTLE_W'(1);
        end
      end

      CHECK: begin
        fail_valid_d = !pass;
        if (!pass) begin
          fail_a_d = a;
        end
        state_d  = APPLY;
        settle_d = SETTLE_LOAD;
        if (phase_q == RANDOM) begin
          lfsr_shift = 1'b1;
          rand_tot_d = sat_inc_r(random_total);
          if (pass) begin
            rand_pass_d = sat_inc_r(random_passed);
          end
          // Last random vector: hand over to the directed patterns
          if ((17'(random_total) + 17'd1) >= 17'(N_RANDOM_TESTS)) begin
            phase_d   = DIRECTED;
            dir_idx_d = '0;
            a_d       = dir_vec(DIR_IDX_W'(0));
          end else begin
            a_d = lfsr_nxt[N_INS-1:0];
          end
        end else begin
          dir_tot_d = sat_inc_d(directed_total);
          if (pass) begin
            dir_pass_d = sat_inc_d(directed_passed);
          end
          if (dir_idx_q == DIR_IDX_W'(N_DIRECTED - 1)) begin
            state_d = DONE;
          end else begin
            dir_idx_d = dir_idx_q + DIR_IDX_W'(1);
            a_d       = dir_vec(dir_idx_q + DIR_IDX_W'(1));
          end
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d       = (state_d == APPLY) || (state_d == CHECK);
    done_d       = (state_d == DONE);
    all_passed_d = done_d && (rand_pass_d == rand_tot_d) && (dir_pass_d == dir_tot_d);
  end

endmodule

// File: tb/tb_gate_test_seq.sv
// Randomized self-checking bench for gate_test_seq.
// Instance A: N_INS=2, 100 random vectors, settle 1, AND gate loopback /
// stuck-at-0 / random injected errors. Instance B: N_INS=6, no random
// vectors, settle 3, golden output delayed by two cycles.
module tb_gate_test_seq;

  localparam int unsigned NA = 2, RA = 100, SA = 1;
  localparam int unsigned NB = 6, RB = 0,   SB = 3;
  localparam logic [31:0] SEED = 32'hACE1_1234;

  logic clk = 1'b0;
  logic rst, start_req, err_cur, stuck;
  bit   sel;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  logic [NA-1:0] a_a, fail_a_a;
  logic          busy_a, done_a, allp_a, fv_a, start_a, y_dut_a, y_gold_a;
  logic [15:0]   rp_a, rt_a;
  logic [2:0]    dp_a, dt_a;

  logic [NB-1:0] a_b, fail_a_b;
  logic          busy_b, done_b, allp_b, fv_b, start_b, y_dut_b, y_gold_b;
  logic [15:0]   rp_b, rt_b;
  logic [2:0]    dp_b, dt_b;
  logic [1:0]    dly_b = '0;

  assign start_a  = start_req && !sel;
  assign start_b  = start_req && sel;
  assign y_gold_a = &a_a;
  assign y_dut_a  = stuck ? 1'b0 : ((&a_a) ^ err_cur);

  always @(posedge clk) dly_b <= {dly_b[0], &a_b};
  assign y_gold_b = dly_b[1];
  assign y_dut_b  = (&a_b) ^ err_cur;

  gate_test_seq #(.N_INS(NA), .N_RANDOM_TESTS(RA), .SETTLE_CYCLES(SA), .LFSR_SEED(SEED)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .y_dut(y_dut_a), .y_golden(y_gold_a),
    .a(a_a), .busy(busy_a), .done(done_a), .all_passed(allp_a), .fail_valid(fv_a),
    .fail_a(fail_a_a), .random_passed(rp_a), .random_total(rt_a),
    .directed_passed(dp_a), .directed_total(dt_a)
  );

  gate_test_seq #(.N_INS(NB), .N_RANDOM_TESTS(RB), .SETTLE_CYCLES(SB), .LFSR_SEED(SEED)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .y_dut(y_dut_b), .y_golden(y_gold_b),
    .a(a_b), .busy(busy_b), .done(done_b), .all_passed(allp_b), .fail_valid(fv_b),
    .fail_a(fail_a_b), .random_passed(rp_b), .random_total(rt_b),
    .directed_passed(dp_b), .directed_total(dt_b)
  );

  // Monitor view of whichever instance is selected
  logic [31:0] m_a, m_busy, m_done, m_allp, m_fv, m_fa, m_rp, m_rt, m_dp, m_dt;
  assign m_a    = sel ? 32'(a_b)      : 32'(a_a);
  assign m_busy = sel ? 32'(busy_b)   : 32'(busy_a);
  assign m_done = sel ? 32'(done_b)   : 32'(done_a);
  assign m_allp = sel ? 32'(allp_b)   : 32'(allp_a);
  assign m_fv   = sel ? 32'(fv_b)     : 32'(fv_a);
  assign m_fa   = sel ? 32'(fail_a_b) : 32'(fail_a_a);
  assign m_rp   = sel ? 32'(rp_b)     : 32'(rp_a);
  assign m_rt   = sel ? 32'(rt_b)     : 32'(rt_a);
  assign m_dp   = sel ? 32'(dp_b)     : 32'(dp_a);
  assign m_dt   = sel ? 32'(dt_b)     : 32'(dt_a);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference LFSR: polynomial x^32+x^22+x^2+x+1, right-shifting Galois
  function automatic logic [31:0] ref_next(input logic [31:0] s);
    logic [31:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 32'h8020_0003;
    return r;
  endfunction

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_a"}, m_a, 0);
    check_eq({tag, "_busy"}, m_busy, 0);
    check_eq({tag, "_done"}, m_done, 0);
    check_eq({tag, "_allp"}, m_allp, 0);
    check_eq({tag, "_fv"}, m_fv, 0);
    check_eq({tag, "_fail_a"}, m_fa, 0);
    check_eq({tag, "_rp"}, m_rp, 0);
    check_eq({tag, "_rt"}, m_rt, 0);
    check_eq({tag, "_dp"}, m_dp, 0);
    check_eq({tag, "_dt"}, m_dt, 0);
  endtask

  // mode 0: loopback, 1: stuck-at-0 DUT, 2: random injected mismatches plus
  // start pulses while busy. abort_k >= 0 resets during that vector.
  task automatic run(input bit dsel, input int mode, input int abort_k);
    int unsigned n, r, s, nv;
    logic [31:0] lf, all_m, lo_m, last_fail;
    logic [31:0] vecs[$];
    bit          errs[$];
    bit          passes[$];
    int          rp, dp, nfail;
    n = dsel ? NB : NA;
    r = dsel ? RB : RA;
    s = dsel ? SB : SA;
    all_m = (32'd1 << n) - 32'd1;
    lo_m  = (32'd1 << (n / 2)) - 32'd1;
    lf = SEED;
    for (int unsigned k = 0; k < r; k++) begin
      vecs.push_back(lf & all_m);
      lf = ref_next(lf);
    end
    vecs.push_back(all_m);
    vecs.push_back(32'd0);
    vecs.push_back(all_m ^ lo_m);
    vecs.push_back(lo_m);
    nv = r + 4;
    rp = 0; dp = 0; nfail = 0; last_fail = 0;
    for (int unsigned k = 0; k < nv; k++) begin
      bit e, p;
      e = (mode == 2) && ($urandom_range(0, 4) == 0);
      p = (mode == 1) ? (vecs[k] != all_m) : !e;
      errs.push_back(e);
      passes.push_back(p);
      if (!p) begin
        nfail++;
        last_fail = vecs[k];
      end else if (k < r) rp++;
      else dp++;
    end

    sel = dsel;
    stuck = (mode == 1);
    err_cur = 1'b0;
    @(negedge clk);
    start_req = 1'b1;
    @(negedge clk);
    for (int unsigned k = 0; k < nv; k++) begin
      for (int unsigned c = 0; c <= s; c++) begin
        if (int'(k) == abort_k && c == 0) begin
          start_req = 1'b0;
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          check_all_zero("abort");
          return;
        end
        start_req = (mode == 2) && ((k == 10 && c == 0) || (k == 30 && c == s));
        err_cur = errs[k];
        check_eq($sformatf("a[%0d.%0d]", k, c), m_a, vecs[k]);
        check_eq($sformatf("busy[%0d.%0d]", k, c), m_busy, 1);
        if (c == 0) begin
          check_eq($sformatf("done_low[%0d]", k), m_done, 0);
          if (k == 0) begin
            check_eq("start_rt", m_rt, 0);
            check_eq("start_rp", m_rp, 0);
            check_eq("start_dt", m_dt, 0);
            check_eq("start_dp", m_dp, 0);
            check_eq("start_fail_a", m_fa, 0);
            check_eq("start_fv", m_fv, 0);
            check_eq("start_allp", m_allp, 0);
          end else begin
            check_eq($sformatf("fail_valid[%0d]", k - 1), m_fv, 32'(!passes[k-1]));
            if (!passes[k-1]) check_eq($sformatf("fail_a[%0d]", k - 1), m_fa, vecs[k-1]);
          end
        end else begin
          check_eq($sformatf("fv_quiet[%0d.%0d]", k, c), m_fv, 0);
        end
        @(negedge clk);
      end
    end
    start_req = 1'b0;
    check_eq("end_done", m_done, 1);
    check_eq("end_busy", m_busy, 0);
    check_eq("end_fv", m_fv, 32'(!passes[nv-1]));
    check_eq("end_rp", m_rp, 32'(rp));
    check_eq("end_rt", m_rt, r);
    check_eq("end_dp", m_dp, 32'(dp));
    check_eq("end_dt", m_dt, 4);
    check_eq("end_allp", m_allp, 32'(nfail == 0));
    check_eq("end_fail_a", m_fa, last_fail);
    @(negedge clk);
    check_eq("hold_done", m_done, 1);
    check_eq("hold_a", m_a, vecs[nv-1]);
  endtask

  initial begin
    rst = 1'b1;
    start_req = 1'b0;
    err_cur = 1'b0;
    stuck = 1'b0;
    sel = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    check_eq("reset_a_b", 32'(a_b), 0);

    run(1'b0, 0, -1);
    run(1'b0, 1, -1);
    run(1'b0, 0, 49);
    run(1'b0, 0, -1);
    run(1'b0, 2, -1);
    run(1'b0, 2, -1);

    run(1'b1, 0, -1);
    run(1'b1, 2, -1);
    run(1'b1, 2, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
